// File: rtl/corrector_hamming.sv
// Hamming SECDED(8,4) corrector: two-stage pipeline with valid/ready flow.
// Stage 1 registers the codeword with its syndrome and global parity.
// Stage 2 classifies the word, fixes a single-bit error and presents
// the data word, syndrome and error flags downstream.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   palabra_in        - codeword {p0,p1,w0,p2,w1,w2,w3,g0}
//   in_valid/in_ready - input handshake
//   dato_out          - decoded data {w0,w1,w2,w3}
//   sindrome_out      - syndrome {s2,s1,s0}
//   error_simple      - single error found and corrected
//   error_doble       - double error found, not corrected
//   posicion_out      - Hamming position of corrected bit (0 = none)
//   out_valid/out_ready - output handshake
//   clr_cnt, cnt_simple, cnt_doble - error counters (SECDED_CNT_EN only)
//
// Optional macro SECDED_CNT_EN adds saturating error counters.

module corrector_hamming #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       palabra_in,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef SECDED_CNT_EN
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_simple,
    output logic [CNT_W-1:0] cnt_doble,
`endif
    output logic [3:0]       dato_out,
    output logic [2:0]       sindrome_out,
    output logic             error_simple,
    output logic             error_doble,
    output logic [3:0]       posicion_out,
    output logic             out_valid,
    input  logic             out_ready
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    // Stage 1 state
    logic       s1_valid_q, s1_valid_d;
    logic [7:0] s1_word_q, s1_word_d;
    logic [2:0] s1_syn_q, s1_syn_d;
    logic       s1_g_q, s1_g_d;

    // Stage 2 (output) state
    logic       s2_valid_q, s2_valid_d;
    logic [3:0] dato_q, dato_d;
    logic [2:0] syn_q, syn_d;
    logic       es_q, es_d;
    logic       ed_q, ed_d;
    logic [3:0] pos_q, pos_d;

    logic       adv2;
    logic       accept;
    logic [7:0] flip_mask;
    logic [7:0] corr_word;

    assign adv2     = !s2_valid_q || out_ready;
    assign in_ready = !rst && (!s1_valid_q || adv2);
    assign accept   = in_valid && in_ready;

    // Position k of the codeword lives at bit (8-k).
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_word_d  = s1_word_q;
        s1_syn_d   = s1_syn_q;
        s1_g_d     = s1_g_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_word_d   = palabra_in;
            s1_syn_d[0] = palabra_in[7] ^ palabra_in[5]
                        ^ palabra_in[3] ^ palabra_in[1];
            s1_syn_d[1] = palabra_in[6] ^ palabra_in[5]
                        ^ palabra_in[2] ^ palabra_in[1];
            s1_syn_d[2] = palabra_in[4] ^ palabra_in[3]
                        ^ palabra_in[2] ^ palabra_in[1];
            s1_g_d      = ^palabra_in;
        end
    end

    // One-hot mask selecting the bit at position S (1..7).
    always_comb begin
        flip_mask = '0;
        for (int k = 1; k <= 7; k++) begin
            flip_mask[8-k] = (s1_syn_q == 3'(k));
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        dato_d     = dato_q;
        syn_d      = syn_q;
        es_d       = es_q;
        ed_d       = ed_q;
        pos_d      = pos_q;
        corr_word  = s1_word_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
        end
        if (adv2 && s1_valid_q) begin
            syn_d = s1_syn_q;
            es_d  = 1'b0;
            ed_d  = 1'b0;
            pos_d = 4'd0;
            case ({s1_syn_q != 3'd0, s1_g_q})
                2'b01: begin
                    // Only g0 flipped: data bits are intact.
                    es_d  = 1'b1;
                    pos_d = 4'd8;
                end
                2'b11: begin
                    corr_word = s1_word_q ^ flip_mask;
                    es_d      = 1'b1;
                    pos_d     = {1'b0, s1_syn_q};
                end
                2'b10: begin
                    ed_d = 1'b1;
                end
                default: begin
                end
            endcase
            dato_d = {corr_word[5], corr_word[3],
                      corr_word[2], corr_word[1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
            s1_syn_q   <= '0;
            s1_g_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            dato_q     <= '0;
            syn_q      <= '0;
            es_q       <= 1'b0;
            ed_q       <= 1'b0;
            pos_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_word_q  <= s1_word_d;
            s1_syn_q   <= s1_syn_d;
            s1_g_q     <= s1_g_d;
            s2_valid_q <= s2_valid_d;
            dato_q     <= dato_d;
            syn_q      <= syn_d;
            es_q       <= es_d;
            ed_q       <= ed_d;
            pos_q      <= pos_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign dato_out     = dato_q;
    assign sindrome_out = syn_q;
    assign error_simple = es_q;
    assign error_doble  = ed_q;
    assign posicion_out = pos_q;

`ifdef SECDED_CNT_EN
    logic [CNT_W-1:0] cnt_simple_q, cnt_simple_d;
    logic [CNT_W-1:0] cnt_doble_q, cnt_doble_d;
    logic             xfer;

    assign xfer = s2_valid_q && out_ready;

    // Clear wins over increment; counters stick at all-ones.
    always_comb begin
        cnt_simple_d = cnt_simple_q;
        cnt_doble_d  = cnt_doble_q;
        if (clr_cnt) begin
            cnt_simple_d = '0;
            cnt_doble_d  = '0;
        end else if (xfer) begin
            if (es_q && cnt_simple_q != '1) begin
                cnt_simple_d = cnt_simple_q + 1'b1;
            end
            if (ed_q && cnt_doble_q != '1) begin
                cnt_doble_d = cnt_doble_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_simple_q <= '0;
            cnt_doble_q  <= '0;
        end else begin
            cnt_simple_q <= cnt_simple_d;
            cnt_doble_q  <= cnt_doble_d;
        end
    end

    assign cnt_simple = cnt_simple_q;
    assign cnt_doble  = cnt_doble_q;
`endif

endmodule

// File: tb/tb_corrector_hamming.sv
// Scoreboard bench for corrector_hamming: directed codewords with
// hand-computed results, backpressure, mid-flight reset, counters.

module tb_corrector_hamming;

    typedef struct packed {
        logic [3:0] dato;
        logic [2:0] syn;
        logic       es;
        logic       ed;
        logic [3:0] pos;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] palabra_in;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] dato_out;
    logic [2:0] sindrome_out;
    logic       error_simple;
    logic       error_doble;
    logic [3:0] posicion_out;
    logic       out_valid;
    logic       out_ready;
`ifdef SECDED_CNT_EN
    logic       clr_cnt;
    logic [1:0] cnt_simple;
    logic [1:0] cnt_doble;
`endif

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

`ifdef SECDED_CNT_EN
    corrector_hamming #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .palabra_in(palabra_in), .in_valid(in_valid),
        .in_ready(in_ready),
        .clr_cnt(clr_cnt), .cnt_simple(cnt_simple),
        .cnt_doble(cnt_doble),
        .dato_out(dato_out), .sindrome_out(sindrome_out),
        .error_simple(error_simple), .error_doble(error_doble),
        .posicion_out(posicion_out), .out_valid(out_valid),
        .out_ready(out_ready)
    );
`else
    corrector_hamming dut (
        .clk(clk), .rst(rst),
        .palabra_in(palabra_in), .in_valid(in_valid),
        .in_ready(in_ready),
        .dato_out(dato_out), .sindrome_out(sindrome_out),
        .error_simple(error_simple), .error_doble(error_doble),
        .posicion_out(posicion_out), .out_valid(out_valid),
        .out_ready(out_ready)
    );
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every output transfer against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 32'({dato_out, sindrome_out, error_simple,
                                   error_doble, posicion_out}), 32'(e));
                chk("flags_exclusive",
                    32'(error_simple & error_doble), 32'd0);
            end
        end
    end

    task automatic send(input logic [7:0] w, input exp_t e,
                        output int waited);
        waited = 0;
        palabra_in = w;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                chk("send_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    logic [7:0] vec_w[9];
    exp_t       vec_e[9];
    int         w;

    initial begin
        vec_w[0] = 8'h66; vec_e[0] = {4'b1011, 3'b000, 1'b0, 1'b0, 4'd0};
        vec_w[1] = 8'h6E; vec_e[1] = {4'b1011, 3'b101, 1'b1, 1'b0, 4'd5};
        vec_w[2] = 8'h67; vec_e[2] = {4'b1011, 3'b000, 1'b1, 1'b0, 4'd8};
        vec_w[3] = 8'h42; vec_e[3] = {4'b0001, 3'b101, 1'b0, 1'b1, 4'd0};
        vec_w[4] = 8'hE6; vec_e[4] = {4'b1011, 3'b001, 1'b1, 1'b0, 4'd1};
        vec_w[5] = 8'h64; vec_e[5] = {4'b1011, 3'b111, 1'b1, 1'b0, 4'd7};
        vec_w[6] = 8'hFF; vec_e[6] = {4'b1111, 3'b000, 1'b0, 1'b0, 4'd0};
        vec_w[7] = 8'hDF; vec_e[7] = {4'b1111, 3'b011, 1'b1, 1'b0, 4'd3};
        vec_w[8] = 8'h00; vec_e[8] = {4'b0000, 3'b000, 1'b0, 1'b0, 4'd0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        palabra_in = 8'h00;
`ifdef SECDED_CNT_EN
        clr_cnt = 1'b0;
`endif
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", 32'({dato_out, sindrome_out, error_simple,
                                error_doble, posicion_out}), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: output appears after the second edge.
        out_ready = 1'b1;
        send(vec_w[0], vec_e[0], w);
        @(negedge clk);
        chk("latency_s1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_s2", 32'(out_valid), 32'd1);
        drain();

        // Back-to-back stream: accepted every cycle.
        for (int i = 0; i < 9; i++) begin
            send(vec_w[i], vec_e[i], w);
            chk("throughput_wait", 32'(w), 32'd0);
        end
        drain();

        // Backpressure: two words fill the pipe, third must wait.
        out_ready = 1'b0;
        send(vec_w[0], vec_e[0], w);
        send(vec_w[1], vec_e[1], w);
        palabra_in = vec_w[2];
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'({out_valid, dato_out, posicion_out,
                                error_simple}),
                32'({1'b1, 4'b1011, 4'd0, 1'b0}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(vec_w[2], vec_e[2], w);
        chk("bp_release_wait", 32'(w), 32'd0);
        drain();

        // Reset with a word sitting at the output.
        out_ready = 1'b0;
        send(vec_w[3], vec_e[3], w);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rerun_state", 32'({in_ready, out_valid}), 32'b10);
        out_ready = 1'b1;
        send(vec_w[6], vec_e[6], w);
        drain();

`ifdef SECDED_CNT_EN
        for (int i = 0; i < 5; i++) begin
            send(vec_w[1], vec_e[1], w);
        end
        drain();
        chk("cnt_simple_sat", 32'(cnt_simple), 32'd3);
        chk("cnt_doble_zero", 32'(cnt_doble), 32'd0);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("cnt_clear", 32'(cnt_simple), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/corrector_hamming.md
Name: corrector_hamming

Overview:
- Downstream stage of the Hamming SECDED(8,4) encoder/syndrome block.
- Receives an 8-bit codeword, possibly corrupted between encoder and this stage, and decodes it in a 2-stage pipeline.
- Recomputes syndrome and global parity, then classifies the error and corrects a single-bit error.
- Delivers the 4-bit data word, syndrome and error flags to the display/LED stage over a valid/ready handshake.

Parameters:
CNT_W, 8, width of the saturating error counters (used only when SECDED_CNT_EN is defined)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
palabra_in  input  8  codeword {p0,p1,w0,p2,w1,w2,w3,g0}; bit7 = Hamming position 1, bit0 = position 8 (g0)
in_valid  input  1  palabra_in valid
in_ready  output  1  block accepts palabra_in this cycle
dato_out  output  4  decoded data {w0,w1,w2,w3}
sindrome_out  output  3  syndrome {s2,s1,s0}
error_simple  output  1  single error detected and corrected
error_doble  output  1  double error detected, not correctable
posicion_out  output  4  Hamming position (1..8) of the corrected bit; 0 = none
out_valid  output  1  outputs valid
out_ready  input  1  consumer accepts outputs

Behaviour:
- Reset: clk single clock; rst asynchronous, active-high. While rst=1, every stage valid=0 and out_valid=0. dato_out, sindrome_out, posicion_out = 0; error_simple, error_doble = 0; in_ready = 0. After release: in_ready=1.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Stage 1 (S1) register: on accept, store palabra_in, together with the following computed from it:
  - s0 = XOR of positions 1,3,5,7
  - s1 = XOR of positions 2,3,6,7
  - s2 = XOR of positions 4,5,6,7
  - G = XOR of all 8 bits
- Stage 2 (S2, output) register, classification:
  - S=0, G=0: no error. posicion=0, both flags 0.
  - S≠0, G=1: single error. Invert the bit at position S; posicion=S; error_simple=1.
  - S=0, G=1: single error in g0. Data untouched; posicion=8; error_simple=1.
  - S≠0, G=0: double error. dato_out = raw uncorrected data bits; posicion=0; error_doble=1.
  - error_simple and error_doble are never both 1.
- Flow control:
  - adv2 = !S2_valid | out_ready; S1 moves into S2 when adv2.
  - in_ready = !S1_valid | adv2 (combinational; 0 during reset).
  - Latency: 2 cycles from accepting edge to out_valid with no stall.
  - Throughput: 1 word/cycle with out_ready=1.
- Boundaries:
  - Full pipeline plus out_ready=0: in_ready=0, no word lost or overwritten.
  - Simultaneous accept, advance and output transfer in one cycle is legal and keeps 1/cycle throughput.
  - Order preserved.
  - rst mid-operation: in-flight words discarded, out_valid drops asynchronously.

Optional Feature:
- SECDED_CNT_EN defined:
  - Adds ports cnt_simple (output, CNT_W), cnt_doble (output, CNT_W) and clr_cnt (input, 1, synchronous clear).
  - Each counter increments by 1 on each output transfer carrying error_simple / error_doble.
  - Counters saturate at 2^CNT_W-1 and reset to 0.
  - clr_cnt has priority over increment in the same cycle.
- SECDED_CNT_EN undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Clean word: palabra_in=8'h66, out_ready=1 -> 2 cycles later out_valid=1, dato_out=4'b1011, sindrome_out=3'b000, posicion_out=0, flags 0.
- Single data error at position 5: palabra_in=8'h6E -> sindrome_out=3'b101, posicion_out=5, error_simple=1, dato_out=4'b1011.
- g0 error: palabra_in=8'h67 -> sindrome_out=3'b000, posicion_out=8, error_simple=1, dato_out=4'b1011.
- Double error at positions 3,6: palabra_in=8'h42 -> sindrome_out=3'b101, error_doble=1, error_simple=0, posicion_out=0, dato_out=4'b0001.
- Backpressure: hold out_ready=0 and stream 8'h66, 8'h6E, 8'h67 -> in_ready=0 after two accepts, outputs frozen on 8'h66 result. Raise out_ready -> all three results delivered in order, one per cycle.
- Reset/counters: assert rst with out_valid=1 -> out_valid=0 immediately. With SECDED_CNT_EN and CNT_W=2, send five 8'h6E -> cnt_simple saturates at 3; clr_cnt=1 -> 0 next cycle.
